// File: rtl/sram_arb_pkg.sv
// Shared encodings for the SRAM-port arbiter: requester owner tags, access
// sizes and the outstanding-transaction bound.
package sram_arb_pkg;

    typedef logic owner_t;

    localparam owner_t OWNER_INST = 1'b0;
    localparam owner_t OWNER_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int MAX_OUTSTANDING_LIMIT = 4;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING_LIMIT + 1);

endpackage

// File: rtl/sram_mem_arbiter_owner_fifo.sv
// One-bit-wide owner FIFO: remembers which requester issued each accepted
// memory transaction so in-order responses can be routed back.
module owner_fifo
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic push_i,
    input  logic din_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the head slot, so a push is still allowed at full.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) cnt_d = cnt_q + CNT_W'(1);
        if (do_pop && !do_push) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_mem_arbiter.sv
// Arbitrates the fetch and load/store requesters onto one SRAM-like port and
// routes in-order responses back. Define ARB_RR_EN for round-robin arbitration.
module sram_mem_arbiter
    import sram_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [1:0]  inst_size,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    logic   fifo_full, fifo_empty, fifo_head;
    logic   lock_q, lock_d;
    owner_t lock_owner_q, lock_owner_d;
    owner_t arb_owner, grant;
    logic   accept, resp_valid;

`ifdef ARB_RR_EN
    owner_t last_q, last_d;

    // On a conflict the requester that lost the previous acceptance goes first.
    always_comb begin
        if (inst_req && data_req) arb_owner = ~last_q;
        else                      arb_owner = data_req ? OWNER_DATA : OWNER_INST;
        last_d = accept ? grant : last_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) last_q <= OWNER_INST;
        else         last_q <= last_d;
    end
`else
    assign arb_owner = data_req ? OWNER_DATA : OWNER_INST;
`endif

    assign grant   = lock_q ? lock_owner_q : arb_owner;
    assign mem_req = resetn & (inst_req | data_req) & ~fifo_full;
    assign accept  = mem_req & mem_addr_ok;

    // A presented-but-unaccepted request keeps its grant until accepted.
    assign lock_d       = mem_req & ~mem_addr_ok;
    assign lock_owner_d = grant;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_INST;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
        end
    end

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = '0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_req) begin
            if (grant == OWNER_DATA) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_size  = inst_size;
                mem_addr  = inst_addr;
            end
        end
    end

    assign inst_addr_ok = accept & (grant == OWNER_INST);
    assign data_addr_ok = accept & (grant == OWNER_DATA);

    // A response with nothing outstanding is dropped without popping.
    assign resp_valid   = mem_data_ok & ~fifo_empty;
    assign inst_data_ok = resp_valid & (fifo_head == OWNER_INST);
    assign data_data_ok = resp_valid & (fifo_head == OWNER_DATA);
    assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
    assign data_rdata   = data_data_ok ? mem_rdata : '0;

    owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (accept),
        .din_i   (grant),
        .pop_i   (resp_valid),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    a_no_orphan_response: assert property (
        @(posedge clk) disable iff (!resetn) mem_data_ok |-> !fifo_empty
    );

endmodule

// File: tb/tb_sram_mem_arbiter.sv
// Randomized bench for sram_mem_arbiter: requester and memory models drive
// the ports; a monitor checks grants, mux fields and response routing.
module tb_sram_mem_arbiter;
    import sram_arb_pkg::*;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [1:0]  inst_size = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = '0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = '0;

    sram_mem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Scoreboard: {owner, rdata} per accepted transaction, in acceptance order.
    logic [32:0] exp_q[$];
    // Memory model: data it will return for each accepted transaction.
    logic [31:0] rsp_q[$];

    // Reference model state (spec-level arbitration rules).
    logic   m_lock_valid = 1'b0;
    owner_t m_lock_owner = OWNER_INST;
    owner_t m_last = OWNER_INST;
    owner_t m_winner = OWNER_INST;
    logic   m_mem_req = 1'b0;
    logic   inst_done = 1'b0, data_done = 1'b0;
    logic   mon_en = 1'b0;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check32({tag, "_hs"}, {27'd0, mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'd0);
        check32({tag, "_inst_rdata"}, inst_rdata, 32'd0);
        check32({tag, "_data_rdata"}, data_rdata, 32'd0);
        check32({tag, "_mem_ctrl"}, {25'd0, mem_wr, mem_size, mem_wstrb}, 32'd0);
        check32({tag, "_mem_addr"}, mem_addr, 32'd0);
        check32({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    task automatic model_eval();
        m_mem_req = (inst_req | data_req) && (rsp_q.size() < MAXO);
        if (m_lock_valid) m_winner = m_lock_owner;
`ifdef ARB_RR_EN
        else if (inst_req && data_req) m_winner = ~m_last;
`endif
        else m_winner = data_req ? OWNER_DATA : OWNER_INST;
    endtask

    // One clock of stimulus plus model bookkeeping after the monitor samples.
    task automatic step(input int inst_pct, input int data_pct, input int ok_pct, input int rsp_pct);
        logic [31:0] d;
        @(posedge clk);
        #1;
        if (inst_done) begin inst_req = 1'b0; inst_done = 1'b0; end
        if (data_done) begin data_req = 1'b0; data_done = 1'b0; end
        if (!inst_req && $urandom_range(0, 99) < inst_pct) begin
            inst_req  = 1'b1;
            inst_addr = 32'h1C00_0000 | ($urandom & 32'h000F_FFFC);
            inst_size = 2'($urandom_range(0, 2));
        end
        if (!data_req && $urandom_range(0, 99) < data_pct) begin
            data_req   = 1'b1;
            data_wr    = 1'($urandom_range(0, 1));
            data_size  = 2'($urandom_range(0, 2));
            data_wstrb = data_wr ? 4'($urandom_range(1, 15)) : 4'd0;
            data_addr  = $urandom;
            data_wdata = data_wr ? $urandom : 32'd0;
        end
        mem_addr_ok = ($urandom_range(0, 99) < ok_pct);
        mem_data_ok = (rsp_q.size() > 0) && ($urandom_range(0, 99) < rsp_pct);
        mem_rdata   = mem_data_ok ? rsp_q[0] : $urandom;
        #1;
        model_eval();
        @(negedge clk);
        #1;
        if (mem_data_ok) void'(rsp_q.pop_front());
        if (m_mem_req && mem_addr_ok) begin
            d = $urandom;
            rsp_q.push_back(d);
            exp_q.push_back({m_winner, d});
            if (m_winner == OWNER_INST) inst_done = 1'b1;
            else                        data_done = 1'b1;
            m_last       = m_winner;
            m_lock_valid = 1'b0;
        end else if (m_mem_req) begin
            m_lock_valid = 1'b1;
            m_lock_owner = m_winner;
        end else begin
            m_lock_valid = 1'b0;
        end
    endtask

    // Monitor: grant/mux checks every cycle, response routing from exp_q.
    always @(negedge clk) begin
        logic        acc;
        logic [32:0] e;
        if (resetn && mon_en) begin
            acc = m_mem_req & mem_addr_ok;
            check32("mem_req", {31'd0, mem_req}, {31'd0, m_mem_req});
            check32("addr_ok", {30'd0, inst_addr_ok, data_addr_ok},
                    {30'd0, acc && (m_winner == OWNER_INST), acc && (m_winner == OWNER_DATA)});
            if (m_mem_req && m_winner == OWNER_DATA) begin
                check32("mem_ctrl", {25'd0, mem_wr, mem_size, mem_wstrb}, {25'd0, data_wr, data_size, data_wstrb});
                check32("mem_addr", mem_addr, data_addr);
                check32("mem_wdata", mem_wdata, data_wdata);
            end else if (m_mem_req) begin
                check32("mem_ctrl", {25'd0, mem_wr, mem_size, mem_wstrb}, {25'd0, 1'b0, inst_size, 4'd0});
                check32("mem_addr", mem_addr, inst_addr);
                check32("mem_wdata", mem_wdata, 32'd0);
            end else begin
                check32("mem_idle", {25'd0, mem_wr, mem_size, mem_wstrb} | mem_addr | mem_wdata, 32'd0);
            end
            if (mem_data_ok || inst_data_ok || data_data_ok) begin
                if (exp_q.size() == 0) begin
                    check32("spurious_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check32("data_ok_route", {30'd0, inst_data_ok, data_data_ok},
                            {30'd0, e[32] == OWNER_INST, e[32] == OWNER_DATA});
                    check32("inst_rdata", inst_rdata, (e[32] == OWNER_INST) ? e[31:0] : 32'd0);
                    check32("data_rdata", data_rdata, (e[32] == OWNER_DATA) ? e[31:0] : 32'd0);
                end
            end else begin
                check32("rsp_idle", {30'd0, inst_data_ok, data_data_ok} | inst_rdata | data_rdata, 32'd0);
            end
        end
    end

    task automatic clear_model();
        rsp_q.delete();
        exp_q.delete();
        m_lock_valid = 1'b0;
        m_last       = OWNER_INST;
        inst_done    = 1'b0;
        data_done    = 1'b0;
    endtask

    initial begin
        int phases[5][5] = '{
            '{60,  0, 100, 50,  40},
            '{70, 70,  60, 50, 300},
            '{80, 80,  20, 40, 200},
            '{90, 90, 100, 50, 150},
            '{90, 90, 100,  0,  20}
        };
        int guard;

        // Reset state, idle inputs and then with both requests raised.
        #12;
        @(negedge clk);
        check_all_zero("reset_idle");
        inst_req = 1'b1;
        data_req = 1'b1;
        inst_addr = 32'h1C00_0000;
        data_addr = 32'h0000_1000;
        #1;
        check_all_zero("reset_req");
        inst_req = 1'b0;
        data_req = 1'b0;
        @(posedge clk);
        #2 resetn = 1'b1;
        mon_en = 1'b1;

        for (int p = 0; p < 5; p++)
            for (int c = 0; c < phases[p][4]; c++)
                step(phases[p][0], phases[p][1], phases[p][2], phases[p][3]);

        // Reset with transactions outstanding and requests still raised.
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        inst_req = 1'b1;
        data_req = 1'b1;
        check32("pre_reset_outstanding", rsp_q.size(), MAXO);
        resetn = 1'b0;
        mem_data_ok = 1'b0;
        #1;
        check_all_zero("mid_reset");
        inst_req = 1'b0;
        data_req = 1'b0;
        clear_model();
        @(posedge clk);
        @(posedge clk);
        #2 resetn = 1'b1;
        mon_en = 1'b1;

        for (int c = 0; c < 400; c++) step(70, 70, 70, 60);

        // Drain: no new requests, let pending ones and responses complete.
        guard = 0;
        while ((rsp_q.size() > 0 || inst_req || data_req) && guard < 100) begin
            step(0, 0, 100, 100);
            guard++;
        end
        check32("drain_timeout", guard, (guard < 100) ? guard : 32'd0);
        @(negedge clk);
        #2;
        check32("exp_q_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
